line_capture: RTL and testbench

- Sits directly downstream of the EOC edge detector and the ST generator in the S10077 sensor path.
- Samples the sensor's ADC output on every TRIG rising edge during a readout and writes the pixels into an internal line buffer.
- Uses EOC_EDGE to close the line, then streams the line out over a valid/ready interface with per-pixel index and an end-of-line marker.
- Feeds the downstream host/UART packetiser.

---
 rtl/s10077_pkg.sv | 14 +
 rtl/line_capture_if.sv | 31 +++
 rtl/line_ram.sv | 27 ++
 rtl/line_capture.sv | 161 ++++++++++++++++
 tb/tb_line_capture.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/s10077_pkg.sv
// Shared types and defaults for the S10077 line capture path.
package s10077_pkg;

    localparam int NPIX_DEFAULT = 1024;
    localparam int ADC_DW       = 12;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } cap_state_t;

endpackage

// File: rtl/line_capture_if.sv
// Pixel stream handshake between line_capture and the host packetiser.
interface line_capture_if
    import s10077_pkg::*;
#(
    parameter int DW = ADC_DW,
    parameter int AW = $clog2(NPIX_DEFAULT)
) ();

    logic          PIX_VALID;
    logic          PIX_READY;
    logic [DW-1:0] PIX_DATA;
    logic [AW-1:0] PIX_INDEX;
    logic          LINE_LAST;

    modport master (
        output PIX_VALID,
        output PIX_DATA,
        output PIX_INDEX,
        output LINE_LAST,
        input  PIX_READY
    );

    modport slave (
        input  PIX_VALID,
        input  PIX_DATA,
        input  PIX_INDEX,
        input  LINE_LAST,
        output PIX_READY
    );

endinterface

// File: rtl/line_ram.sv
// Simple dual-port line buffer, registered read, no reset on the array.
module line_ram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_capture.sv
// Captures one S10077 line on TRIG edges, then streams it out with index/last.
module line_capture
    import s10077_pkg::*;
#(
    parameter int NPIX = NPIX_DEFAULT,
    parameter int DW   = ADC_DW
) (
    input  logic          FPGA_CLK,
    input  logic          FPGA_RST,
    input  logic          ST,
    input  logic          TRIG,
    input  logic          EOC_EDGE,
    input  logic [DW-1:0] ADC_DATA,
    line_capture_if.master pix,
    output logic [15:0]   LINE_COUNT,
    output logic          OVERRUN,
    output logic          BUSY
);

    localparam int AW = $clog2(NPIX);
    localparam logic [AW:0] ONE    = (AW+1)'(1);
    localparam logic [AW:0] NPIX_W = (AW+1)'(NPIX);

    cap_state_t state;

    logic st_s1, st_s2, st_d;
    logic trig_s1, trig_s2, trig_d;
    logic st_rise, st_fall, trig_rise;

    logic [AW:0] wptr, wcount, npix, last_idx;
    logic [AW:0] rd_ptr, s1_idx;
    logic        s1_valid;
    logic        we, re, load, hs;
    logic [DW-1:0] rdata;

    assign st_rise   = st_s2 & ~st_d;
    assign st_fall   = ~st_s2 & st_d;
    assign trig_rise = trig_s2 & ~trig_d;

    assign we       = (state == CAPTURE) && trig_rise && (wptr != NPIX_W);
    assign wcount   = wptr + {{AW{1'b0}}, we};
    assign last_idx = npix - ONE;

    // Two-stage read pipe: RAM output register feeds the output register.
    assign hs   = pix.PIX_VALID && pix.PIX_READY;
    assign load = s1_valid && (!pix.PIX_VALID || pix.PIX_READY);
    assign re   = (state == DRAIN) && (rd_ptr != npix)
                  && (!s1_valid || load);

    assign BUSY = (state != IDLE);

    line_ram #(
        .DEPTH (NPIX),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (FPGA_CLK),
        .we    (we),
        .waddr (wptr[AW-1:0]),
        .wdata (ADC_DATA),
        .re    (re),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state         <= IDLE;
            st_s1         <= 1'b0;
            st_s2         <= 1'b0;
            st_d          <= 1'b0;
            trig_s1       <= 1'b0;
            trig_s2       <= 1'b0;
            trig_d        <= 1'b0;
            wptr          <= '0;
            npix          <= '0;
            rd_ptr        <= '0;
            s1_idx        <= '0;
            s1_valid      <= 1'b0;
            pix.PIX_VALID <= 1'b0;
            pix.PIX_DATA  <= '0;
            pix.PIX_INDEX <= '0;
            pix.LINE_LAST <= 1'b0;
            LINE_COUNT    <= '0;
            OVERRUN       <= 1'b0;
        end else begin
            st_s1   <= ST;
            st_s2   <= st_s1;
            st_d    <= st_s2;
            trig_s1 <= TRIG;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;

            unique case (state)
                IDLE: begin
                    if (st_rise) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (EOC_EDGE) begin
                        state <= IDLE;
                    end else if (st_fall) begin
                        state <= CAPTURE;
                        wptr  <= '0;
                    end
                end
                CAPTURE: begin
                    if (trig_rise) begin
                        if (we) begin
                            wptr <= wptr + ONE;
                        end else begin
                            OVERRUN <= 1'b1;
                        end
                    end
                    // A TRIG edge coinciding with EOC is already in wcount.
                    if (EOC_EDGE) begin
                        if (wcount == '0) begin
                            state <= IDLE;
                        end else begin
                            state    <= DRAIN;
                            npix     <= wcount;
                            rd_ptr   <= '0;
                            s1_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (st_rise) begin
                        OVERRUN <= 1'b1;
                    end
                    if (re) begin
                        rd_ptr   <= rd_ptr + ONE;
                        s1_idx   <= rd_ptr;
                        s1_valid <= 1'b1;
                    end else if (load) begin
                        s1_valid <= 1'b0;
                    end
                    if (load) begin
                        pix.PIX_VALID <= 1'b1;
                        pix.PIX_DATA  <= rdata;
                        pix.PIX_INDEX <= s1_idx[AW-1:0];
                        pix.LINE_LAST <= (s1_idx == last_idx);
                    end else if (hs) begin
                        pix.PIX_VALID <= 1'b0;
                        pix.LINE_LAST <= 1'b0;
                    end
                    if (hs && pix.LINE_LAST) begin
                        LINE_COUNT    <= LINE_COUNT + 16'd1;
                        state         <= IDLE;
                        pix.PIX_VALID <= 1'b0;
                        pix.LINE_LAST <= 1'b0;
                        s1_valid      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_capture.sv
// Scoreboard bench for line_capture with an 8-pixel line buffer.
module tb_line_capture;

    localparam int NP = 8;

    typedef struct packed {
        logic [11:0] data;
        logic [2:0]  idx;
        logic        last;
    } beat_t;

    logic        FPGA_CLK = 1'b0;
    logic        FPGA_RST = 1'b1;
    logic        ST = 1'b0;
    logic        TRIG = 1'b0;
    logic        EOC_EDGE = 1'b0;
    logic [11:0] ADC_DATA = '0;
    logic [15:0] LINE_COUNT;
    logic        OVERRUN;
    logic        BUSY;

    line_capture_if #(.DW(12), .AW(3)) pix ();

    line_capture #(.NPIX(NP), .DW(12)) dut (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST   (FPGA_RST),
        .ST         (ST),
        .TRIG       (TRIG),
        .EOC_EDGE   (EOC_EDGE),
        .ADC_DATA   (ADC_DATA),
        .pix        (pix),
        .LINE_COUNT (LINE_COUNT),
        .OVERRUN    (OVERRUN),
        .BUSY       (BUSY)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    stall_err = 0;

    task automatic send_line(input int ntrig, input logic [11:0] base);
        int nexp;
        beat_t b;
        nexp = (ntrig < NP) ? ntrig : NP;
        @(negedge FPGA_CLK) ST = 1'b1;
        repeat (4) @(negedge FPGA_CLK);
        ST = 1'b0;
        repeat (5) @(negedge FPGA_CLK);
        for (int i = 0; i < ntrig; i++) begin
            ADC_DATA = base + 12'(i);
            TRIG = 1'b1;
            if (i < NP) begin
                b.data = base + 12'(i);
                b.idx  = 3'(i);
                b.last = (i == nexp - 1);
                exp_q.push_back(b);
            end
            repeat (3) @(negedge FPGA_CLK);
            TRIG = 1'b0;
            repeat (3) @(negedge FPGA_CLK);
        end
        repeat (3) @(negedge FPGA_CLK);
        EOC_EDGE = 1'b1;
        @(negedge FPGA_CLK) EOC_EDGE = 1'b0;
    endtask

    task automatic trig_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            ADC_DATA = 12'hFFF;
            TRIG = 1'b1;
            repeat (3) @(negedge FPGA_CLK);
            TRIG = 1'b0;
            repeat (3) @(negedge FPGA_CLK);
        end
    endtask

    task automatic collect(input int max_beats, input bit bp,
                           input int budget, output bit timeout);
        int nb;
        bit stalled;
        beat_t cur, prev;
        nb = 0;
        stalled = 1'b0;
        prev = '0;
        timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge FPGA_CLK);
            cur.data = pix.PIX_DATA;
            cur.idx  = pix.PIX_INDEX;
            cur.last = pix.LINE_LAST;
            if (stalled && (!pix.PIX_VALID || cur !== prev)) stall_err++;
            pix.PIX_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix.PIX_VALID && pix.PIX_READY) begin
                got_q.push_back(cur);
                nb++;
                if (cur.last || nb == max_beats) begin
                    timeout = 1'b0;
                    @(posedge FPGA_CLK);
                    #1;
                    return;
                end
            end
            stalled = pix.PIX_VALID && !pix.PIX_READY;
            prev = cur;
        end
    endtask

    task automatic do_reset();
        @(negedge FPGA_CLK) FPGA_RST = 1'b1;
        @(negedge FPGA_CLK) FPGA_RST = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge FPGA_CLK);
        FPGA_RST = 1'b0;
        @(negedge FPGA_CLK);
        n_chk++;
        if ({pix.PIX_VALID, pix.LINE_LAST, OVERRUN, BUSY} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {pix.PIX_VALID, pix.LINE_LAST, OVERRUN, BUSY});
        end
        n_chk++;
        if (pix.PIX_DATA !== 12'h0 || pix.PIX_INDEX !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%0d want 0/0",
                     pix.PIX_DATA, pix.PIX_INDEX);
        end
        n_chk++;
        if (LINE_COUNT !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", LINE_COUNT);
        end
    endtask

    task automatic test_nominal();
        bit to;
        beat_t g, e;
        send_line(8, 12'h100);
        collect(NP, 1'b0, 300, to);
        n_chk++;
        if (to || got_q.size() != 8) begin
            n_fail++;
            $display("FAIL nominal_beats: got %0d want 8", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL nominal_beat: got %h/%0d/%b want %h/%0d/%b",
                         g.data, g.idx, g.last, e.data, e.idx, e.last);
            end
        end
        @(negedge FPGA_CLK);
        n_chk++;
        if (LINE_COUNT !== 16'd1 || OVERRUN !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_status: got %0d/%b/%b want 1/0/0",
                     LINE_COUNT, OVERRUN, BUSY);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        beat_t g, e;
        stall_err = 0;
        send_line(8, 12'h100);
        collect(NP, 1'b1, 500, to);
        n_chk++;
        if (to || got_q.size() != 8) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d want 8", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL bp_beat: got %h/%0d/%b want %h/%0d/%b",
                         g.data, g.idx, g.last, e.data, e.idx, e.last);
            end
        end
        n_chk++;
        if (stall_err != 0) begin
            n_fail++;
            $display("FAIL bp_stall_hold: got %0d changes want 0", stall_err);
        end
        @(negedge FPGA_CLK);
        n_chk++;
        if (LINE_COUNT !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 2", LINE_COUNT);
        end
    endtask

    task automatic test_empty();
        int vcnt;
        vcnt = 0;
        send_line(0, 12'h000);
        for (int c = 0; c < 30; c++) begin
            @(negedge FPGA_CLK);
            if (pix.PIX_VALID) vcnt++;
        end
        n_chk++;
        if (vcnt != 0 || LINE_COUNT !== 16'd2 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_line: got valid=%0d cnt=%0d busy=%b want 0/2/0",
                     vcnt, LINE_COUNT, BUSY);
        end
    endtask

    task automatic test_overflow();
        bit to;
        beat_t g, e;
        send_line(10, 12'h200);
        collect(16, 1'b0, 300, to);
        n_chk++;
        if (to || got_q.size() != 8) begin
            n_fail++;
            $display("FAIL ovf_beats: got %0d want 8", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ovf_beat: got %h/%0d/%b want %h/%0d/%b",
                         g.data, g.idx, g.last, e.data, e.idx, e.last);
            end
        end
        repeat (20) @(negedge FPGA_CLK);
        n_chk++;
        if (OVERRUN !== 1'b1 || LINE_COUNT !== 16'd3) begin
            n_fail++;
            $display("FAIL ovf_status: got %b/%0d want 1/3", OVERRUN, LINE_COUNT);
        end
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        int vcnt;
        beat_t g, e;
        send_line(8, 12'h300);
        collect(3, 1'b0, 300, to);
        pix.PIX_READY = 1'b0;
        for (int c = 0; c < 20 && !pix.PIX_VALID; c++) @(negedge FPGA_CLK);
        n_chk++;
        if (to || !pix.PIX_VALID || pix.PIX_INDEX !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_stop_index: got %b/%0d want 1/3",
                     pix.PIX_VALID, pix.PIX_INDEX);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL mid_beat: got %h/%0d want %h/%0d",
                         g.data, g.idx, e.data, e.idx);
            end
        end
        exp_q.delete();
        got_q.delete();
        do_reset();
        n_chk++;
        if (pix.PIX_VALID !== 1'b0 || LINE_COUNT !== 16'd0 || BUSY !== 1'b0
            || OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b/%0d/%b/%b want 0/0/0/0",
                     pix.PIX_VALID, LINE_COUNT, BUSY, OVERRUN);
        end
        pix.PIX_READY = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge FPGA_CLK);
            if (pix.PIX_VALID) vcnt++;
        end
        n_chk++;
        if (vcnt != 0) begin
            n_fail++;
            $display("FAIL mid_no_partial: got %0d valid cycles want 0", vcnt);
        end
        send_line(8, 12'h380);
        collect(NP, 1'b0, 300, to);
        n_chk++;
        if (to || got_q.size() != 8) begin
            n_fail++;
            $display("FAIL mid_next_beats: got %0d want 8", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL mid_next_beat: got %h/%0d/%b want %h/%0d/%b",
                         g.data, g.idx, g.last, e.data, e.idx, e.last);
            end
        end
        @(negedge FPGA_CLK);
        n_chk++;
        if (LINE_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_next_count: got %0d want 1", LINE_COUNT);
        end
    endtask

    task automatic test_st_during_drain();
        bit to1, to2;
        int vcnt;
        beat_t g, e;
        do_reset();
        send_line(8, 12'h400);
        collect(2, 1'b0, 300, to1);
        pix.PIX_READY = 1'b0;
        for (int c = 0; c < 20 && !pix.PIX_VALID; c++) @(negedge FPGA_CLK);
        ST = 1'b1;
        repeat (6) @(negedge FPGA_CLK);
        collect(16, 1'b0, 300, to2);
        n_chk++;
        if (to1 || to2 || got_q.size() != 8) begin
            n_fail++;
            $display("FAIL std_beats: got %0d want 8", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL std_beat: got %h/%0d/%b want %h/%0d/%b",
                         g.data, g.idx, g.last, e.data, e.idx, e.last);
            end
        end
        trig_pulses(3);
        ST = 1'b0;
        repeat (5) @(negedge FPGA_CLK);
        trig_pulses(3);
        EOC_EDGE = 1'b1;
        @(negedge FPGA_CLK) EOC_EDGE = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge FPGA_CLK);
            if (pix.PIX_VALID) vcnt++;
        end
        n_chk++;
        if (vcnt != 0 || OVERRUN !== 1'b1 || LINE_COUNT !== 16'd1
            || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL std_status: got v=%0d ovr=%b cnt=%0d busy=%b want 0/1/1/0",
                     vcnt, OVERRUN, LINE_COUNT, BUSY);
        end
    endtask

    initial begin
        pix.PIX_READY = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_empty();
        test_overflow();
        test_reset_mid_drain();
        test_st_during_drain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
